motion_cmd_sequencer: RTL and testbench
=======================================

Name: motion_cmd_sequencer

Overview:
- Queues move commands from the PS-side register interface and runs them one at a time on a single ddr_motor_ctrl channel.
- For each move it resets the pulse channel, loads step/accel/decel/mode/dir, enables it, and detects completion from pul_state. It then reports done and starts the next move.
- Sits between the AXI-lite register bank and one motor channel. Adds pause, abort and arm-timeout handling.

Parameters:
- CMD_DEPTH, 4, command queue depth; power of 2, at least 2.
- RST_CYC, 8, cycles mc_pul_rst is held high per move, 1..255.
- ARM_TMO, 1024, cycles allowed for mc_pul_state to rise after enable, at least 4.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cmd_valid  in  1  command offer
- cmd_ready  out  1  queue not full
- cmd_step  in  32  pulses in move
- cmd_accel_end  in  16  last accel pulse index
- cmd_decel_begin  in  16  first decel pulse index
- cmd_mode  in  2  01 accel/decel, 10 uniform
- cmd_dir  in  1  direction
- pause  in  1  level; hold motion (uniform mode only)
- abort  in  1  pulse; kill current move, flush queue
- mc_pul_rst  out  1  to channel pul_rst
- mc_en  out  1  to channel en
- mc_pul_mode  out  2  to channel pul_mode
- mc_pul_stop  out  1  to channel pul_stop
- mc_step  out  32  to channel step
- mc_accel_end  out  16  to channel accel_end
- mc_decel_begin  out  16  to channel decel_begin
- mc_pul_dir  out  1  to channel pul_dir
- mc_pul_state  in  1  from channel pul_state
- busy  out  1  state != IDLE or queue non-empty
- q_level  out  $clog2(CMD_DEPTH)+1  queue occupancy
- move_done  out  1  one-cycle pulse per completed move
- move_err  out  1  one-cycle pulse per rejected or failed move
- err_code  out  2  01 bad command, 10 arm timeout, 11 aborted; holds until next error
- done_cnt  out  16  completed moves, wraps

Behaviour:
Reset values:
- All outputs 0, except mc_pul_rst=1 and cmd_ready=1.
- Queue empty, FSM in IDLE.

Queue:
- Write when cmd_valid && cmd_ready.
- Read is a 1-cycle pop in IDLE.
- Simultaneous push and pop while full is refused (cmd_ready=0 while full).

FSM states and transitions:
- IDLE: mc_en=0, mc_pul_mode=00, mc_pul_rst=1. If queue non-empty, pop and latch the command into the mc_* config outputs, then go to CHECK.
- CHECK (1 cycle): if step==0, or mode is not 01/10, or (mode==01 and accel_end>decel_begin), or (mode==01 and decel_begin>=step), then pulse move_err with err_code=01 and return to IDLE. Otherwise go to RESET.
- RESET: mc_pul_rst=1 for exactly RST_CYC cycles. Then deassert it and go to ARM.
- ARM: drive mc_pul_mode=latched mode and mc_en=1, and start the timeout counter.
  - If mc_pul_state==1, go to RUN.
  - If the counter reaches ARM_TMO, go to FAIL with err_code=10.
- RUN: wait for mc_pul_state==0.
  - If mode==10 and pause=1, hold mc_pul_stop=1 and ignore mc_pul_state (it drops during a uniform-mode stop).
  - In mode 01, pause is ignored and mc_pul_stop stays 0.
  - A low mc_pul_state seen with pause=0 for 2 consecutive cycles means completion. Go to DONE.
- DONE (1 cycle): pulse move_done, increment done_cnt, set mc_en=0 and mc_pul_mode=00, go to IDLE.
- FAIL (1 cycle): pulse move_err, set mc_en=0, mode=00, mc_pul_rst=1, go to IDLE.

Abort:
- In any state, abort=1 flushes the queue that cycle.
- If the FSM is not in IDLE, it forces mc_pul_stop=1 for 1 cycle and goes to FAIL with err_code=11.
- Abort in IDLE with an empty queue does nothing.
- abort and a same-cycle push: abort wins; the pushed command is discarded.

Other rules:
- Latched config is stable from CHECK until the next IDLE pop.
- mc_pul_dir changes only while mc_pul_rst=1.
- The done_cnt increment wraps 0xFFFF to 0.
- Asynchronous reset mid-move returns everything to reset values immediately. The channel is held in pul_rst.

Decomposition:
- Package motion_seq_pkg: FSM state enum (IDLE, CHECK, RESET, ARM, RUN, DONE, FAIL); mode constants MODE_ADCEL=2'b01, MODE_UNIFORM=2'b10; error code constants; packed command struct (step, accel_end, decel_begin, mode, dir = 67 bits).
- Sub-module cmd_fifo: synchronous FIFO of the command struct with depth CMD_DEPTH, level output and flush input.

Test Plan:
- Push one uniform move (step=100, mode=10), then model pul_state high for 100 cycles and low after -> mc_pul_rst high exactly 8 cycles, mc_en rises next cycle, move_done one pulse, done_cnt=1.
- Push 4 accel moves (step=200, accel_end=50, decel_begin=150) with a 5th offered while full -> cmd_ready=0 at q_level=4; all 4 complete in order; the 5th is accepted after the first pop.
- Push step=0, then mode=11, then accel_end=60/decel_begin=40 -> three move_err pulses, err_code=01 each, channel never enabled.
- Run a uniform move, assert pause 30 cycles while the model drops pul_state -> mc_pul_stop=1 for those cycles, no move_done; completion is reported only after pause=0 and pul_state low 2 cycles.
- Model holding pul_state=0 after enable -> move_err after 1024 cycles in ARM, err_code=10, mc_pul_rst=1.
- Queue 3 moves, pulse abort mid-RUN of the first -> mc_pul_stop pulse, err_code=11, q_level=0, no further moves started; deassert rst_n mid-RUN -> all outputs at reset values asynchronously.

Source files
------------

// File: rtl/motion_seq_pkg.sv
// Shared types for the motion command sequencer: FSM states, channel modes,
// error codes and the queued command record.
package motion_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        RESET,
        ARM,
        RUN,
        DONE,
        FAIL
    } seq_state_e;

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ADCEL   = 2'b01;
    localparam logic [1:0] MODE_UNIFORM = 2'b10;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_BAD_CMD = 2'b01;
    localparam logic [1:0] ERR_ARM_TMO = 2'b10;
    localparam logic [1:0] ERR_ABORT   = 2'b11;

    typedef struct packed {
        logic [31:0] step;
        logic [15:0] accel_end;
        logic [15:0] decel_begin;
        logic [1:0]  mode;
        logic        dir;
    } cmd_t;

    // A command the channel cannot execute sensibly: empty move, unknown mode,
    // or an accel/decel profile whose phases overlap or run past the end.
    function automatic logic cmd_is_bad(input cmd_t c);
        logic bad;
        bad = (c.step == 32'd0) || !((c.mode == MODE_ADCEL) || (c.mode == MODE_UNIFORM));
        if (c.mode == MODE_ADCEL) begin
            bad = bad || (c.accel_end > c.decel_begin) || (32'(c.decel_begin) >= c.step);
        end
        return bad;
    endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Show-ahead FIFO of move commands with occupancy output and a one-cycle flush
// that wins over any same-cycle push or pop.
module cmd_fifo
    import motion_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     wr_en,
    input  cmd_t                     wr_data,
    input  logic                     rd_en,
    output cmd_t                     rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    cmd_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [LW-1:0]   count;
    logic            do_wr;
    logic            do_rd;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign level   = count;
    assign rd_data = mem[rd_ptr];
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + LW'(do_wr) - LW'(do_rd);
        end
    end

endmodule

// File: rtl/motion_cmd_sequencer.sv
// Runs queued move commands one at a time on a single pulse channel:
// validate, reset channel, arm, wait for completion, report.
module motion_cmd_sequencer
    import motion_seq_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int RST_CYC   = 8,
    parameter int ARM_TMO   = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [31:0]                  cmd_step,
    input  logic [15:0]                  cmd_accel_end,
    input  logic [15:0]                  cmd_decel_begin,
    input  logic [1:0]                   cmd_mode,
    input  logic                         cmd_dir,
    input  logic                         pause,
    input  logic                         abort,
    output logic                         mc_pul_rst,
    output logic                         mc_en,
    output logic [1:0]                   mc_pul_mode,
    output logic                         mc_pul_stop,
    output logic [31:0]                  mc_step,
    output logic [15:0]                  mc_accel_end,
    output logic [15:0]                  mc_decel_begin,
    output logic                         mc_pul_dir,
    input  logic                         mc_pul_state,
    output logic                         busy,
    output logic [$clog2(CMD_DEPTH):0]   q_level,
    output logic                         move_done,
    output logic                         move_err,
    output logic [1:0]                   err_code,
    output logic [15:0]                  done_cnt
);
    localparam int TW = $clog2(ARM_TMO);

    seq_state_e      state;
    seq_state_e      state_nxt;
    cmd_t            cmd_in;
    cmd_t            cfg;
    cmd_t            fifo_dout;
    logic            q_full;
    logic            q_empty;
    logic            fifo_pop;
    logic [7:0]      rst_cnt;
    logic [TW-1:0]   tmo_cnt;
    logic            low_seen;
    logic            run_low;
    logic            pause_hold;
    logic [1:0]      fail_code;

    assign cmd_in = '{step: cmd_step, accel_end: cmd_accel_end, decel_begin: cmd_decel_begin,
                      mode: cmd_mode, dir: cmd_dir};

    assign fifo_pop  = (state == IDLE) && !q_empty && !abort;
    assign cmd_ready = !q_full;

    cmd_fifo #(.DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (abort),
        .wr_en   (cmd_valid),
        .wr_data (cmd_in),
        .rd_en   (fifo_pop),
        .rd_data (fifo_dout),
        .full    (q_full),
        .empty   (q_empty),
        .level   (q_level)
    );

    // Rejected commands are routed through FAIL so every error report looks
    // the same: move_err high for one cycle with err_code already updated.
    always_comb begin
        state_nxt  = state;
        fail_code  = ERR_NONE;
        run_low    = 1'b0;
        pause_hold = 1'b0;
        case (state)
            IDLE: begin
                if (fifo_pop) state_nxt = CHECK;
            end
            CHECK: begin
                if (cmd_is_bad(cfg)) begin
                    state_nxt = FAIL;
                    fail_code = ERR_BAD_CMD;
                end else begin
                    state_nxt = RESET;
                end
            end
            RESET: begin
                if (rst_cnt == 8'(RST_CYC - 1)) state_nxt = ARM;
            end
            ARM: begin
                if (mc_pul_state) begin
                    state_nxt = RUN;
                end else if (tmo_cnt == TW'(ARM_TMO - 1)) begin
                    state_nxt = FAIL;
                    fail_code = ERR_ARM_TMO;
                end
            end
            RUN: begin
                // A uniform-mode stop drops pul_state, so it must not count as completion.
                if ((cfg.mode == MODE_UNIFORM) && pause) begin
                    pause_hold = 1'b1;
                end else if (!mc_pul_state) begin
                    run_low = 1'b1;
                    if (low_seen) state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            FAIL:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE) && (state != FAIL)) begin
            state_nxt = FAIL;
            fail_code = ERR_ABORT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cfg      <= '0;
            rst_cnt  <= '0;
            tmo_cnt  <= '0;
            low_seen <= 1'b0;
            err_code <= ERR_NONE;
            done_cnt <= '0;
        end else begin
            state    <= state_nxt;
            rst_cnt  <= (state == RESET) ? rst_cnt + 8'd1 : 8'd0;
            tmo_cnt  <= (state == ARM) ? tmo_cnt + 1'b1 : '0;
            low_seen <= run_low;
            if (fifo_pop) begin
                cfg <= fifo_dout;
            end
            if ((state_nxt == FAIL) && (state != FAIL)) begin
                err_code <= fail_code;
            end
            if ((state == RUN) && (state_nxt == DONE)) begin
                done_cnt <= done_cnt + 16'd1;
            end
        end
    end

    assign mc_pul_rst     = (state == IDLE) || (state == CHECK) || (state == RESET) || (state == FAIL);
    assign mc_en          = (state == ARM) || (state == RUN);
    assign mc_pul_mode    = mc_en ? cfg.mode : MODE_OFF;
    assign mc_pul_stop    = pause_hold || (abort && (state != IDLE));
    assign mc_step        = cfg.step;
    assign mc_accel_end   = cfg.accel_end;
    assign mc_decel_begin = cfg.decel_begin;
    assign mc_pul_dir     = cfg.dir;
    assign busy           = (state != IDLE) || !q_empty;
    assign move_done      = (state == DONE);
    assign move_err       = (state == FAIL);

endmodule

// File: tb/tb_motion_cmd_sequencer.sv
// Directed bench for motion_cmd_sequencer with a simple pulse-channel model.
module tb_motion_cmd_sequencer;

    localparam int RST_CYC = 8;
    localparam int ARM_TMO = 1024;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_step;
    logic [15:0] cmd_accel_end;
    logic [15:0] cmd_decel_begin;
    logic [1:0]  cmd_mode;
    logic        cmd_dir;
    logic        pause;
    logic        abort;
    logic        mc_pul_rst;
    logic        mc_en;
    logic [1:0]  mc_pul_mode;
    logic        mc_pul_stop;
    logic [31:0] mc_step;
    logic [15:0] mc_accel_end;
    logic [15:0] mc_decel_begin;
    logic        mc_pul_dir;
    logic        mc_pul_state;
    logic        busy;
    logic [2:0]  q_level;
    logic        move_done;
    logic        move_err;
    logic [1:0]  err_code;
    logic [15:0] done_cnt;

    motion_cmd_sequencer #(.CMD_DEPTH(4), .RST_CYC(RST_CYC), .ARM_TMO(ARM_TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmd_valid       (cmd_valid),
        .cmd_ready       (cmd_ready),
        .cmd_step        (cmd_step),
        .cmd_accel_end   (cmd_accel_end),
        .cmd_decel_begin (cmd_decel_begin),
        .cmd_mode        (cmd_mode),
        .cmd_dir         (cmd_dir),
        .pause           (pause),
        .abort           (abort),
        .mc_pul_rst      (mc_pul_rst),
        .mc_en           (mc_en),
        .mc_pul_mode     (mc_pul_mode),
        .mc_pul_stop     (mc_pul_stop),
        .mc_step         (mc_step),
        .mc_accel_end    (mc_accel_end),
        .mc_decel_begin  (mc_decel_begin),
        .mc_pul_dir      (mc_pul_dir),
        .mc_pul_state    (mc_pul_state),
        .busy            (busy),
        .q_level         (q_level),
        .move_done       (move_done),
        .move_err        (move_err),
        .err_code        (err_code),
        .done_cnt        (done_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters and scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [34:0] exp_q [$];
    logic [34:0] exp_w;
    int en_rises  = 0;
    int done_seen = 0;
    int err_seen  = 0;
    logic prev_en  = 1'b0;
    logic prev_dir = 1'b0;
    int exp_done   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Each channel enable must present the next expected command, in queue order.
    always @(negedge clk) begin
        if (move_done) done_seen++;
        if (move_err) err_seen++;
        if (mc_en && !prev_en) begin
            en_rises++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_enable: got step %0d expected no enable", mc_step);
            end else begin
                exp_w = exp_q.pop_front();
                check("enable_cfg", {mc_pul_mode, mc_pul_dir, mc_step}, exp_w);
            end
        end
        if (mc_pul_dir !== prev_dir) check("dir_change_under_rst", mc_pul_rst, 1'b1);
        prev_en  = mc_en;
        prev_dir = mc_pul_dir;
    end

    // ---------------- channel model ----------------
    int model_len  = 20;
    bit model_dead = 1'b0;
    int remaining  = 0;
    int arm_dly    = 0;
    bit started    = 1'b0;

    initial begin
        mc_pul_state = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (!mc_en || mc_pul_rst) begin
                remaining = 0;
                arm_dly   = 0;
                started   = 1'b0;
            end else if (!started) begin
                if (!model_dead) begin
                    arm_dly++;
                    if (arm_dly == 2) begin
                        started   = 1'b1;
                        remaining = model_len;
                    end
                end
            end else if ((remaining > 0) && !mc_pul_stop) begin
                remaining--;
            end
            mc_pul_state = started && (remaining > 0) && !mc_pul_stop;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push(input logic [31:0] step, input logic [15:0] ae, input logic [15:0] db,
                        input logic [1:0] mode, input logic dir);
        int n = 0;
        cmd_valid       = 1'b1;
        cmd_step        = step;
        cmd_accel_end   = ae;
        cmd_decel_begin = db;
        cmd_mode        = mode;
        cmd_dir         = dir;
        while (!cmd_ready && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) timeout_fail("push_ready");
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // which: 0 = mc_en high, 1 = mc_pul_state high, 2 = busy low
    task automatic wait_sig(input string name, input int which, input int limit);
        int n = 0;
        bit hit = 1'b0;
        while (!hit && (n < limit)) begin
            case (which)
                0:       hit = mc_en;
                1:       hit = mc_pul_state;
                default: hit = !busy;
            endcase
            if (!hit) begin
                @(negedge clk);
                n++;
            end
        end
        if (!hit) timeout_fail(name);
    endtask

    // Stops on the cycle move_done or move_err is seen; low_run is how many
    // consecutive low pul_state cycles preceded that cycle.
    task automatic wait_end(input int limit, output int low_run);
        int n = 0;
        bit fin = 1'b0;
        low_run = 0;
        while (!fin) begin
            @(negedge clk);
            if (move_done || move_err) begin
                fin = 1'b1;
            end else begin
                n++;
                low_run = mc_pul_state ? 0 : low_run + 1;
                if (n >= limit) begin
                    timeout_fail("wait_end");
                    fin = 1'b1;
                end
            end
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [31:0] step;
        logic [15:0] accel_end;
        logic [15:0] decel_begin;
        logic [1:0]  mode;
        logic        dir;
        bit          exp_ok;
    } vec_t;

    vec_t vecs [10];

    initial begin
        int lr;
        int cnt;
        int n;
        int e0;
        int stop_hi;
        bit any_done;

        vecs[0] = '{32'd100, 16'd0,   16'd0,   2'b10, 1'b1, 1'b1};
        vecs[1] = '{32'd200, 16'd50,  16'd150, 2'b01, 1'b0, 1'b1};
        vecs[2] = '{32'd0,   16'd0,   16'd0,   2'b10, 1'b1, 1'b0};
        vecs[3] = '{32'd100, 16'd0,   16'd0,   2'b11, 1'b0, 1'b0};
        vecs[4] = '{32'd200, 16'd60,  16'd40,  2'b01, 1'b1, 1'b0};
        vecs[5] = '{32'd150, 16'd50,  16'd150, 2'b01, 1'b0, 1'b0};
        vecs[6] = '{32'd151, 16'd150, 16'd150, 2'b01, 1'b1, 1'b1};
        vecs[7] = '{32'd100, 16'd0,   16'd0,   2'b00, 1'b0, 1'b0};
        vecs[8] = '{32'd50,  16'd60,  16'd40,  2'b10, 1'b1, 1'b1};
        vecs[9] = '{32'd1,   16'd0,   16'd0,   2'b10, 1'b0, 1'b1};

        rst_n = 1'b1; cmd_valid = 1'b0; cmd_step = '0; cmd_accel_end = '0;
        cmd_decel_begin = '0; cmd_mode = '0; cmd_dir = 1'b0; pause = 1'b0; abort = 1'b0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);

        // reset values
        check("rst_mc_pul_rst", mc_pul_rst, 1'b1);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_mc_en", mc_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_q_level", q_level, 3'd0);
        check("rst_outputs", {move_done, move_err, err_code, mc_pul_stop, mc_pul_mode}, 7'd0);
        check("rst_done_cnt", done_cnt, 16'd0);
        check("rst_mc_cfg", {mc_step, mc_accel_end, mc_decel_begin, mc_pul_dir}, 65'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // single uniform move: arm latency, one done pulse, debounce length
        model_len = 100;
        exp_q.push_back({2'b10, 1'b1, 32'd100});
        push(32'd100, 16'd0, 16'd0, 2'b10, 1'b1);
        cnt = 0;
        while (!mc_en && (cnt < 50)) begin
            cnt++;
            @(negedge clk);
        end
        check("arm_latency", cnt, 2 + RST_CYC);
        check("arm_pul_rst_low", mc_pul_rst, 1'b0);
        check("arm_mode", mc_pul_mode, 2'b10);
        wait_end(3000, lr);
        exp_done++;
        check("t1_move_done", move_done, 1'b1);
        check("t1_low_run", lr, 2);
        check("t1_done_cnt", done_cnt, exp_done);
        @(negedge clk);
        check("t1_done_one_cycle", move_done, 1'b0);
        check("t1_idle_outputs", {mc_en, mc_pul_rst, mc_pul_mode}, 4'b0100);

        // table: accepted vs rejected commands
        model_len = 20;
        for (int i = 0; i < 10; i++) begin
            cnt = en_rises;
            if (vecs[i].exp_ok) begin
                exp_q.push_back({vecs[i].mode, vecs[i].dir, vecs[i].step});
                exp_done++;
            end
            push(vecs[i].step, vecs[i].accel_end, vecs[i].decel_begin, vecs[i].mode, vecs[i].dir);
            wait_end(3000, lr);
            if (vecs[i].exp_ok) begin
                check($sformatf("vec%0d_done", i), move_done, 1'b1);
                check($sformatf("vec%0d_low_run", i), lr, 2);
                check($sformatf("vec%0d_done_cnt", i), done_cnt, exp_done);
            end else begin
                check($sformatf("vec%0d_err", i), {move_err, err_code, mc_en}, 4'b1010);
            end
            @(negedge clk);
            check($sformatf("vec%0d_en_rises", i), en_rises - cnt, vecs[i].exp_ok ? 1 : 0);
        end

        // full queue: one long move running, four queued, a fifth offered while full
        model_len = 100;
        e0 = done_seen;
        exp_q.push_back({2'b10, 1'b0, 32'd300});
        push(32'd300, 16'd0, 16'd0, 2'b10, 1'b0);
        wait_sig("wait_en_fullq", 0, 50);
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back({2'b01, 1'(i), 32'(200 + i)});
            push(32'(200 + i), 16'd50, 16'd150, 2'b01, 1'(i));
        end
        check("full_q_level", q_level, 3'd4);
        check("full_cmd_ready", cmd_ready, 1'b0);
        check("full_busy", busy, 1'b1);
        exp_q.push_back({2'b10, 1'b1, 32'd77});
        cmd_valid = 1'b1;
        repeat (3) @(negedge clk);
        check("full_offer_refused", {cmd_ready, q_level}, 4'b0100);
        push(32'd77, 16'd0, 16'd0, 2'b10, 1'b1);
        wait_sig("wait_idle_fullq", 2, 5000);
        @(negedge clk);
        exp_done += 6;
        check("fullq_done_pulses", done_seen - e0, 6);
        check("fullq_done_cnt", done_cnt, exp_done);

        // uniform pause: stop held, no completion while paused
        model_len = 80;
        exp_q.push_back({2'b10, 1'b0, 32'd80});
        push(32'd80, 16'd0, 16'd0, 2'b10, 1'b0);
        wait_sig("wait_run_pause", 1, 100);
        repeat (10) @(negedge clk);
        pause = 1'b1;
        stop_hi = 0;
        any_done = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            stop_hi += int'(mc_pul_stop);
            any_done |= move_done;
        end
        check("pause_stop_cycles", stop_hi, 30);
        check("pause_no_done", any_done, 1'b0);
        pause = 1'b0;
        wait_end(3000, lr);
        exp_done++;
        check("pause_done", move_done, 1'b1);
        check("pause_low_run", lr, 2);
        check("pause_done_cnt", done_cnt, exp_done);
        @(negedge clk);

        // accel/decel mode ignores pause
        model_len = 30;
        pause = 1'b1;
        exp_q.push_back({2'b01, 1'b1, 32'd200});
        push(32'd200, 16'd50, 16'd150, 2'b01, 1'b1);
        wait_sig("wait_en_adcel_pause", 0, 50);
        stop_hi = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            stop_hi += int'(mc_pul_stop);
        end
        check("adcel_pause_no_stop", stop_hi, 0);
        wait_end(3000, lr);
        exp_done++;
        check("adcel_pause_done", move_done, 1'b1);
        pause = 1'b0;
        @(negedge clk);

        // arm timeout: channel never reports activity
        model_dead = 1'b1;
        exp_q.push_back({2'b10, 1'b0, 32'd10});
        push(32'd10, 16'd0, 16'd0, 2'b10, 1'b0);
        wait_sig("wait_en_tmo", 0, 50);
        n = 0;
        while (mc_en && (n < 2000)) begin
            n++;
            @(negedge clk);
        end
        check("tmo_arm_cycles", n, ARM_TMO);
        check("tmo_err", {move_err, err_code}, 3'b110);
        check("tmo_chan_idle", {mc_pul_rst, mc_en, mc_pul_mode}, 4'b1000);
        model_dead = 1'b0;
        @(negedge clk);

        // abort mid-run with two queued moves
        model_len = 60;
        exp_q.push_back({2'b10, 1'b1, 32'd60});
        push(32'd60, 16'd0, 16'd0, 2'b10, 1'b1);
        wait_sig("wait_en_abort", 0, 50);
        push(32'd61, 16'd0, 16'd0, 2'b10, 1'b0);
        push(32'd62, 16'd0, 16'd0, 2'b10, 1'b1);
        check("abort_q_level_before", q_level, 3'd2);
        wait_sig("wait_run_abort", 1, 100);
        repeat (5) @(negedge clk);
        cnt = en_rises;
        abort = 1'b1;
        #1;
        check("abort_stop", mc_pul_stop, 1'b1);
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("abort_err", {move_err, err_code}, 3'b111);
        check("abort_q_flushed", q_level, 3'd0);
        check("abort_chan", {mc_pul_rst, mc_en, mc_pul_stop}, 3'b100);
        repeat (40) @(negedge clk);
        check("abort_no_restart", en_rises - cnt, 0);
        check("abort_idle", busy, 1'b0);

        // abort while idle together with a push: push is dropped, nothing reported
        e0 = err_seen;
        cmd_step = 32'd40; cmd_accel_end = '0; cmd_decel_begin = '0; cmd_mode = 2'b10; cmd_dir = 1'b0;
        cmd_valid = 1'b1;
        abort = 1'b1;
        #1;
        check("idle_abort_no_stop", mc_pul_stop, 1'b0);
        @(posedge clk);
        #1;
        abort = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        check("idle_abort_push_dropped", q_level, 3'd0);
        repeat (20) @(negedge clk);
        check("idle_abort_no_err", err_seen - e0, 0);
        check("idle_abort_no_enable", en_rises - cnt, 0);
        check("err_code_holds", err_code, 2'b11);

        // asynchronous reset during a move
        exp_q.push_back({2'b10, 1'b1, 32'd55});
        push(32'd55, 16'd0, 16'd0, 2'b10, 1'b1);
        wait_sig("wait_run_reset", 1, 100);
        push(32'd56, 16'd0, 16'd0, 2'b10, 1'b0);
        check("reset_q_level_before", q_level, 3'd1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_mc_pul_rst", mc_pul_rst, 1'b1);
        check("arst_ready_en", {cmd_ready, mc_en, busy}, 3'b100);
        check("arst_q_level", q_level, 3'd0);
        check("arst_counts", {done_cnt, err_code, mc_pul_mode}, 20'd0);
        check("arst_mc_step", mc_step, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = en_rises;
        repeat (30) @(negedge clk);
        check("post_reset_quiet", {busy, 32'(en_rises - cnt)}, 33'd0);
        check("exp_q_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
